// File: rtl/i2s_receiver.sv
// I2S receiver: deserialises sd MSB-first on sck into left/right words with a pair-valid strobe.
// Define I2S_RX_FRAME_ERR_EN to enable the frame_err word-length error pulse.
module i2s_receiver #(
  parameter int unsigned SR_WIDTH = 32
) (
  input  logic                sck,
  input  logic                reset,
  input  logic                sd,
  input  logic                ws,
  output logic [SR_WIDTH-1:0] data_L,
  output logic [SR_WIDTH-1:0] data_R,
  output logic                valid,
  output logic                frame_err
);

  localparam int unsigned             CW      = $clog2(SR_WIDTH + 1);
  localparam logic [CW-1:0]           FULL    = CW'(SR_WIDTH);
  localparam logic [SR_WIDTH-1:0]     MSB_ONE = {1'b1, {(SR_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t              state, state_n;
  logic                ws_d;
  logic [CW-1:0]       count, count_n;
  logic [SR_WIDTH-1:0] shift, shift_n;
  logic [SR_WIDTH-1:0] left_hold, left_hold_n;
  logic [SR_WIDTH-1:0] data_l_n, data_r_n;
  logic                valid_n, frame_err_n;

  logic                rise_c, fall_c, room_c;
  logic [SR_WIDTH-1:0] word_c;

`ifdef I2S_RX_FRAME_ERR_EN
  logic                ovf, ovf_n;
  logic                short_c, long_c;
`endif

  // Word-select edges and the slot word including this cycle's bit
  assign rise_c = ws & ~ws_d;
  assign fall_c = ~ws & ws_d;
  assign room_c = (count != FULL);
  assign word_c = (room_c && sd) ? (shift | (MSB_ONE >> count)) : shift;

`ifdef I2S_RX_FRAME_ERR_EN
  // Completed word is short if fewer than SR_WIDTH bits including this one
  assign short_c = (count < (FULL - CW'(1)));
  assign long_c  = ovf | ~room_c;
`endif

  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      state     <= SYNC;
      ws_d      <= 1'b0;
      count     <= '0;
      shift     <= '0;
      left_hold <= '0;
      data_L    <= '0;
      data_R    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      ws_d      <= ws;
      count     <= count_n;
      shift     <= shift_n;
      left_hold <= left_hold_n;
      data_L    <= data_l_n;
      data_R    <= data_r_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
`ifdef I2S_RX_FRAME_ERR_EN
      ovf       <= ovf_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    shift_n     = shift;
    left_hold_n = left_hold;
    data_l_n    = data_L;
    data_r_n    = data_R;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
    ovf_n       = ovf;
`endif

    case (state)
      SYNC: begin
        // Data is ignored until the first falling ws edge opens a left slot
        shift_n = '0;
        count_n = '0;
`ifdef I2S_RX_FRAME_ERR_EN
        ovf_n   = 1'b0;
`endif
        if (fall_c) state_n = LEFT;
      end

      LEFT, RIGHT: begin
        shift_n = word_c;
        count_n = room_c ? (count + CW'(1)) : count;
`ifdef I2S_RX_FRAME_ERR_EN
        ovf_n   = ovf | ~room_c;
`endif
        if (rise_c || fall_c) begin
          shift_n = '0;
          count_n = '0;
`ifdef I2S_RX_FRAME_ERR_EN
          ovf_n   = 1'b0;
`endif
        end

        if ((state == LEFT) && rise_c) begin
          left_hold_n = word_c;
          state_n     = RIGHT;
`ifdef I2S_RX_FRAME_ERR_EN
          frame_err_n = short_c | long_c;
`endif
        end

        // Right LSB completes the pair: publish both words together
        if ((state == RIGHT) && fall_c) begin
          data_l_n = left_hold;
          data_r_n = word_c;
          valid_n  = 1'b1;
          state_n  = LEFT;
`ifdef I2S_RX_FRAME_ERR_EN
          frame_err_n = short_c | long_c;
`endif
        end
      end

      default: state_n = SYNC;
    endcase
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: word-level reference model built from per-slot bit queues,
// checked every cycle, plus literal expectations for the directed frames.
module tb_i2s_receiver;

  localparam int unsigned SR = 32;

  logic          sck;
  logic          reset;
  logic          sd;
  logic          ws;
  logic [SR-1:0] data_L;
  logic [SR-1:0] data_R;
  logic          valid;
  logic          frame_err;

  int errors = 0;
  int checks = 0;

  i2s_receiver #(.SR_WIDTH(SR)) dut (
    .sck      (sck),
    .reset    (reset),
    .sd       (sd),
    .ws       (ws),
    .data_L   (data_L),
    .data_R   (data_R),
    .valid    (valid),
    .frame_err(frame_err)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect the bits of each slot, pack on ws edges
  logic          m_bits[$];
  bit            m_sync = 1'b0;
  logic          m_prev = 1'b0;
  logic [SR-1:0] m_left = '0;
  logic [SR-1:0] e_l = '0;
  logic [SR-1:0] e_r = '0;
  logic          e_v = 1'b0;
  logic          e_f = 1'b0;

  function automatic logic [SR-1:0] pack_word();
    logic [SR-1:0] w;
    w = '0;
    for (int i = 0; i < m_bits.size() && i < int'(SR); i++)
      w[int'(SR) - 1 - i] = m_bits[i];
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge sck or posedge reset);
      if (reset) begin
        m_bits.delete();
        m_sync = 1'b0;
        m_prev = 1'b0;
        m_left = '0;
        e_l    = '0;
        e_r    = '0;
        e_v    = 1'b0;
        e_f    = 1'b0;
      end else begin
        e_v = 1'b0;
        e_f = 1'b0;
        if (m_sync) m_bits.push_back(sd);
        if (ws != m_prev) begin
          if (!m_sync) begin
            if (!ws) m_sync = 1'b1;
          end else begin
            if (ws) begin
              m_left = pack_word();
            end else begin
              e_l = m_left;
              e_r = pack_word();
              e_v = 1'b1;
            end
`ifdef I2S_RX_FRAME_ERR_EN
            e_f = (m_bits.size() != int'(SR));
`endif
          end
          m_bits.delete();
        end
        m_prev = ws;
      end
    end
  end

  // Compare process: every cycle out of reset, just after the active edge
  initial begin
    forever begin
      @(posedge sck);
      #1;
      if (!reset) begin
        chk("cyc_data_L", data_L, e_l);
        chk("cyc_data_R", data_R, e_r);
        chk("cyc_valid", valid, e_v);
        chk("cyc_frame_err", frame_err, e_f);
      end
    end
  end

  task automatic drive(input logic w, input logic b);
    @(negedge sck);
    ws = w;
    sd = b;
  endtask

  // One slot of n bits MSB first; ws flips on the LSB as in I2S
  task automatic send_slot(input logic ch, input logic [63:0] data, input int n);
    for (int i = 0; i < n; i++)
      drive((i == n - 1) ? ~ch : ch, data[n - 1 - i]);
  endtask

  task automatic send_frame(input logic [SR-1:0] l, input logic [SR-1:0] r);
    send_slot(1'b0, 64'(l), 32);
    send_slot(1'b1, 64'(r), 32);
    @(posedge sck);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    ws    = 1'b0;
    sd    = 1'b0;
    repeat (3) @(posedge sck);
    #2;
    chk("rst_data_L", data_L, 0);
    chk("rst_data_R", data_R, 0);
    chk("rst_valid", valid, 0);
    chk("rst_frame_err", frame_err, 0);

    // Partial left then right slot in flight; reset released mid right slot
    for (int i = 0; i < 10; i++) drive(1'b0, 1'($urandom));
    for (int i = 0; i < 5; i++) drive(1'b1, 1'($urandom));
    @(negedge sck);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom));
    drive(1'b0, 1'($urandom));
    @(posedge sck);
    #2;
    chk("sync_data_L", data_L, 0);
    chk("sync_valid", valid, 0);

    send_frame(32'hA5A5_0001, 32'h5A5A_8002);
    chk("f1_data_L", data_L, 32'hA5A5_0001);
    chk("f1_data_R", data_R, 32'h5A5A_8002);
    chk("f1_valid", valid, 1);
    send_frame(32'hFFFF_FFFF, 32'h0000_0000);
    chk("f2_data_L", data_L, 32'hFFFF_FFFF);
    chk("f2_data_R", data_R, 32'h0000_0000);
    send_frame($urandom, $urandom);

    // Short 24-bit slots, left-justified
    send_slot(1'b0, 64'h12_3456, 24);
    send_slot(1'b1, 64'hAB_CDEF, 24);
    @(posedge sck);
    #2;
    chk("w24_data_L", data_L, 32'h1234_5600);
    chk("w24_data_R", data_R, 32'hABCD_EF00);
`ifdef I2S_RX_FRAME_ERR_EN
    chk("w24_frame_err", frame_err, 1);
`else
    chk("w24_frame_err", frame_err, 0);
`endif

    // Long 40-bit slots, extra bits dropped
    send_slot(1'b0, {24'h0, 32'hDEAD_BEEF, 8'h5C}, 40);
    send_slot(1'b1, {24'h0, 32'hDEAD_BEEF, 8'hA3}, 40);
    @(posedge sck);
    #2;
    chk("w40_data_L", data_L, 32'hDEAD_BEEF);
    chk("w40_data_R", data_R, 32'hDEAD_BEEF);
`ifdef I2S_RX_FRAME_ERR_EN
    chk("w40_frame_err", frame_err, 1);
`else
    chk("w40_frame_err", frame_err, 0);
`endif

    // Random slot lengths and contents
    for (int k = 0; k < 200; k++)
      send_slot(1'(k % 2), {$urandom, $urandom}, int'($urandom_range(1, 40)));

    // One-cycle reset at bit 10 of a right slot
    send_slot(1'b0, 64'($urandom), 32);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'($urandom));
    @(negedge sck);
    reset = 1'b1;
    #1;
    chk("arst_data_L", data_L, 0);
    chk("arst_data_R", data_R, 0);
    chk("arst_valid", valid, 0);
    chk("arst_frame_err", frame_err, 0);
    @(negedge sck);
    reset = 1'b0;
    for (int i = 0; i < 21; i++) drive(1'b1, 1'($urandom));
    drive(1'b0, 1'($urandom));
    send_frame(32'h0BAD_F00D, 32'h600D_CAFE);
    chk("arst_f_data_L", data_L, 32'h0BAD_F00D);
    chk("arst_f_data_R", data_R, 32'h600D_CAFE);
    chk("arst_f_valid", valid, 1);

    // ws toggling every cycle with sd=1
    for (int i = 0; i < 20; i++) drive((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
    @(posedge sck);
    #2;
    chk("tog_data_L", data_L, 32'h8000_0000);
    chk("tog_data_R", data_R, 32'h8000_0000);
    chk("tog_valid", valid, 1);

    repeat (4) drive(1'b0, 1'b0);
    @(posedge sck);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
